// File: rtl/pipe_track_ctrl.sv
// Pipeline sequencing and destination tracking for the 5-stage core:
// stage enables, ID->WB destination carry, squash, halt/drain, stall stats.
module pipe_track_ctrl #(
  parameter int STALL_MAX = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_F,
  input  logic             stall_D,
  input  logic             flush_E,
  input  logic [4:0]       RD_DEC,
  input  logic             RF_LE_DEC,
  input  logic             L_DEC,
  input  logic             CC_WE_DEC,
  input  logic             squash_next,
  input  logic             halt_req,
  output logic             PC_LE,
  output logic             IF_ID_LE,
  output logic             ID_NOP_ID,
  output logic             ID_NOP_EX,
  output logic [4:0]       RD_EX,
  output logic [4:0]       RD_MEM,
  output logic [4:0]       RD_WB,
  output logic             RF_LE_EX,
  output logic             RF_LE_MEM,
  output logic             RF_LE_WB,
  output logic             L_EX,
  output logic             CC_WE_EX,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_err
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  localparam int RUN_W = $clog2(STALL_MAX + 1);

  state_t           state;
  logic [RUN_W-1:0] run_len;
  logic             drained;
  logic             ex_bubble;

  assign PC_LE     = ~rst & ~stall_F & (state == RUN);
  assign IF_ID_LE  = ~rst & ~stall_D;
  assign ex_bubble = flush_E | ID_NOP_ID | stall_D;
  assign drained   = ID_NOP_ID & ID_NOP_EX
                   & ~RF_LE_MEM & ~RF_LE_WB;

  always_ff @(posedge clk) begin
    if (rst) begin
      ID_NOP_ID <= 1'b1;
      ID_NOP_EX <= 1'b1;
      RD_EX     <= '0;
      RD_MEM    <= '0;
      RD_WB     <= '0;
      RF_LE_EX  <= 1'b0;
      RF_LE_MEM <= 1'b0;
      RF_LE_WB  <= 1'b0;
      L_EX      <= 1'b0;
      CC_WE_EX  <= 1'b0;
    end else begin
      // outside RUN, fetch is frozen so IF/ID only takes bubbles
      if (IF_ID_LE)
        ID_NOP_ID <= squash_next | (state != RUN);
      if (ex_bubble) begin
        ID_NOP_EX <= 1'b1;
        RD_EX     <= '0;
        RF_LE_EX  <= 1'b0;
        L_EX      <= 1'b0;
        CC_WE_EX  <= 1'b0;
      end else begin
        ID_NOP_EX <= 1'b0;
        RD_EX     <= RD_DEC;
        RF_LE_EX  <= RF_LE_DEC;
        L_EX      <= L_DEC;
        CC_WE_EX  <= CC_WE_DEC;
      end
      RD_MEM    <= RD_EX;
      RF_LE_MEM <= RF_LE_EX & ~ID_NOP_EX;
      RD_WB     <= RD_MEM;
      RF_LE_WB  <= RF_LE_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (halt_req)
            state <= DRAIN;
        end
        DRAIN: begin
          if (!halt_req) begin
            state <= RUN;
          end else if (drained) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      run_len   <= '0;
      stall_err <= 1'b0;
    end else begin
      if (stall_D && state == RUN && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      // run length saturates at the limit; the flag is sticky
      if (!stall_D)
        run_len <= '0;
      else if (run_len != RUN_W'(STALL_MAX))
        run_len <= run_len + RUN_W'(1);
      if (stall_D && run_len >= RUN_W'(STALL_MAX - 1))
        stall_err <= 1'b1;
    end
  end

endmodule
